// File: rtl/counter_arb_pkg.sv
// Shared definitions for the interval-counter arbiter: FSM state encoding
// and default sizing.
package counter_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/counter_interval_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward
// from ptr, wrapping past the top index back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDXW  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDXW-1:0]  idx,
  output logic             valid
);

  // cand_idx[k] is the requester index examined k-th, i.e. (ptr + k) mod N_REQ
  logic [IDXW-1:0] cand_idx [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDXW:0] sum;
      assign sum = {1'b0, ptr} + (IDXW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDXW+1)'(N_REQ)) ?
                            IDXW'(sum - (IDXW+1)'(N_REQ)) : sum[IDXW-1:0];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one to ptr wins
  always_comb begin
    idx    = '0;
    valid  = 1'b0;
    onehot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        idx   = cand_idx[k];
        valid = 1'b1;
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/counter_interval_arbiter.sv
// One shared up-counter time-multiplexed between N_REQ requesters. A
// round-robin pick in IDLE hands the counter to one owner, which counts
// from 0 up to its latched length and then gets a one-cycle done pulse.
module counter_interval_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       q
);

  localparam int IDXW = $clog2(N_REQ);

  state_t             state_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [N_REQ-1:0]   done_reg;
  logic               busy_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   target_reg;
  logic [IDXW-1:0]    ptr_reg;
  logic [IDXW-1:0]    owner_reg;

  logic [N_REQ-1:0]   win_onehot;
  logic [IDXW-1:0]    win_idx;
  logic               win_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (win_onehot),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  // Arbitration, counting and completion FSM; every output is a register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      done_reg   <= '0;
      busy_reg   <= 1'b0;
      q_reg      <= '0;
      target_reg <= '0;
      ptr_reg    <= '0;
      owner_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= '0;
          q_reg    <= '0;
          if (win_valid) begin
            state_reg  <= COUNT;
            grant_reg  <= win_onehot;
            busy_reg   <= 1'b1;
            target_reg <= len[win_idx*WIDTH +: WIDTH];
            owner_reg  <= win_idx;
            // Winner drops to lowest priority for the next round
            ptr_reg    <= (win_idx == IDXW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          end else begin
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end
        end
        COUNT: begin
          // Abort takes precedence over reaching the target
          if (!req[owner_reg]) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            q_reg     <= '0;
          end else if (q_reg == target_reg) begin
            state_reg <= DONE;
            done_reg  <= grant_reg;
          end else begin
            q_reg <= q_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          done_reg  <= '0;
          busy_reg  <= 1'b0;
          q_reg     <= '0;
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          done_reg  <= '0;
          busy_reg  <= 1'b0;
          q_reg     <= '0;
        end
      endcase
    end
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;
  assign q     = q_reg;

endmodule

// File: tb/tb_counter_interval_arbiter.sv
// Cycle-by-cycle bench for counter_interval_arbiter (N_REQ=4, WIDTH=4).
// Each driven cycle pushes its expected outputs to a scoreboard queue which
// is popped and compared just after the clock edge that consumes the inputs.
module tb_counter_interval_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] len = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_interval_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .q     (q)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    logic [3:0] q;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] len;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic exp_t ex(logic [3:0] g, logic [3:0] d, logic b, logic [3:0] qq);
    exp_t r;
    r.g = g; r.d = d; r.b = b; r.q = qq;
    return r;
  endfunction

  function automatic void add(logic rst_n, logic [3:0] r, logic [15:0] l, exp_t e);
    vec_t v;
    v.rst_n = rst_n; v.req = r; v.len = l; v.e = e;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then compare the outputs that edge produces
  task automatic cyc(input logic rst_n, input logic [3:0] r, input logic [15:0] l,
                     input exp_t e, input string nm);
    exp_t want;
    @(negedge clk);
    reset = rst_n;
    req   = r;
    len   = l;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    checks++;
    if ({grant, done, busy, q} !== want) begin
      errors++;
      $display("FAIL %s: got grant=%b done=%b busy=%b q=%0d, expected grant=%b done=%b busy=%b q=%0d",
               nm, grant, done, busy, q, want.g, want.d, want.b, want.q);
    end else begin
      $display("cyc %s: req=%b grant=%b done=%b busy=%b q=%0d ok", nm, r, grant, done, busy, q);
    end
  endtask

  localparam logic [3:0] RR_ORDER [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

  initial begin
    // ---- Table: reset/idle, single interval, round-robin fairness ----
    add(1'b0, 4'b1111, 16'h0000, ex(0, 0, 0, 0));
    add(1'b0, 4'b1111, 16'h0000, ex(0, 0, 0, 0));
    for (int i = 0; i < 5; i++) add(1'b1, 4'b0000, 16'h0000, ex(0, 0, 0, 0));
    // len[1]=3: q 0,1,2,3,3 with done on the 5th grant cycle
    add(1'b1, 4'b0010, 16'h0030, ex(4'b0010, 0, 1, 0));
    add(1'b1, 4'b0010, 16'h0030, ex(4'b0010, 0, 1, 1));
    add(1'b1, 4'b0010, 16'h0030, ex(4'b0010, 0, 1, 2));
    add(1'b1, 4'b0010, 16'h0030, ex(4'b0010, 0, 1, 3));
    add(1'b1, 4'b0010, 16'h0030, ex(4'b0010, 4'b0010, 1, 3));
    add(1'b1, 4'b0000, 16'h0030, ex(0, 0, 0, 0));
    // Reset returns the pointer to 0 before the fairness run
    add(1'b0, 4'b0000, 16'h1111, ex(0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      add(1'b1, 4'b1011, 16'h1111, ex(RR_ORDER[k], 0, 1, 0));
      add(1'b1, 4'b1011, 16'h1111, ex(RR_ORDER[k], 0, 1, 1));
      add(1'b1, 4'b1011, 16'h1111, ex(RR_ORDER[k], RR_ORDER[k], 1, 1));
      add(1'b1, 4'b1011, 16'h1111, ex(0, 0, 0, 0));
    end
    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].rst_n, vecs[i].req, vecs[i].len, vecs[i].e, $sformatf("vec[%0d]", i));

    // ---- Abort: req[2] len=9 dropped at q=4, req[0] served next ----
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 4'b0100, 16'h0902, ex(4'b0100, 0, 1, 4'(i)), "abort_count");
    cyc(1'b1, 4'b0001, 16'h0902, ex(0, 0, 0, 0), "abort_edge");
    cyc(1'b1, 4'b0001, 16'h0902, ex(4'b0001, 0, 1, 0), "after_abort_grant");
    cyc(1'b1, 4'b0001, 16'h0902, ex(4'b0001, 0, 1, 1), "after_abort_q1");
    cyc(1'b1, 4'b0001, 16'h0902, ex(4'b0001, 0, 1, 2), "after_abort_q2");
    cyc(1'b1, 4'b0001, 16'h0902, ex(4'b0001, 4'b0001, 1, 2), "after_abort_done");
    cyc(1'b1, 4'b0000, 16'h0902, ex(0, 0, 0, 0), "after_abort_idle");

    // ---- len=0, lone requester re-grant, abort coinciding with q==target ----
    cyc(1'b1, 4'b0010, 16'h0000, ex(4'b0010, 0, 1, 0), "len0_grant");
    cyc(1'b1, 4'b0010, 16'h0000, ex(4'b0010, 4'b0010, 1, 0), "len0_done");
    cyc(1'b1, 4'b0010, 16'h0000, ex(0, 0, 0, 0), "len0_gap");
    cyc(1'b1, 4'b0010, 16'h0000, ex(4'b0010, 0, 1, 0), "len0_regrant");
    cyc(1'b1, 4'b0000, 16'h0000, ex(0, 0, 0, 0), "len0_abort_at_target");

    // ---- len=15: no wrap; len changes during COUNT are ignored ----
    cyc(1'b1, 4'b0010, 16'h00F0, ex(4'b0010, 0, 1, 0), "len15_grant");
    for (int i = 1; i < 16; i++)
      cyc(1'b1, 4'b0010, 16'h0020, ex(4'b0010, 0, 1, 4'(i)), "len15_count");
    cyc(1'b1, 4'b0010, 16'h0020, ex(4'b0010, 4'b0010, 1, 15), "len15_done");
    cyc(1'b1, 4'b0000, 16'h0020, ex(0, 0, 0, 0), "len15_idle");

    // ---- Reset mid-COUNT at q=6; pointer must return to 0 ----
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 4'b0100, 16'h0900, ex(4'b0100, 0, 1, 4'(i)), "rst_mid_count");
    cyc(1'b0, 4'b0100, 16'h0900, ex(0, 0, 0, 0), "rst_mid_edge");
    // With ptr=0, req=1100 picks index 2 (a stale ptr of 3 would pick 3)
    cyc(1'b1, 4'b1100, 16'h0000, ex(4'b0100, 0, 1, 0), "rst_ptr_grant");
    cyc(1'b1, 4'b1100, 16'h0000, ex(4'b0100, 4'b0100, 1, 0), "rst_ptr_done");
    cyc(1'b1, 4'b1000, 16'h0000, ex(0, 0, 0, 0), "rst_gap");
    cyc(1'b1, 4'b1000, 16'h0000, ex(4'b1000, 0, 1, 0), "req3_grant");
    cyc(1'b1, 4'b1000, 16'h0000, ex(4'b1000, 4'b1000, 1, 0), "req3_done");
    cyc(1'b1, 4'b0000, 16'h0000, ex(0, 0, 0, 0), "req3_idle");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_interval_arbiter.md
Name: counter_interval_arbiter

Overview:
Shares one WIDTH-bit up-counter between N_REQ requesters. Each requester asks for a timed interval of a programmed length. A round-robin arbiter grants the counter to one requester at a time, and a small FSM runs the count and signals completion. The block sits between the counter datapath and the blocks that need interval timing.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 4, counter and interval length width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on clk rising edge; 0 = reset
req  input  N_REQ  per-requester request level; held high until done or abort
len  input  N_REQ*WIDTH  per-requester terminal count; requester i uses bits [i*WIDTH +: WIDTH]
grant  output  N_REQ  one-hot (or zero) owner of the counter
done  output  N_REQ  one-cycle completion pulse to the owner
busy  output  1  high whenever the counter is owned (state COUNT or DONE)
q  output  WIDTH  current count value

Behaviour:
- All outputs are registered. While reset=0 at an edge, the next state is:
  - state IDLE, grant=0, done=0, busy=0, q=0
  - rr pointer = 0, meaning index 0 has highest priority next.
- FSM states: IDLE, COUNT, DONE. Encoding comes from the package.
- IDLE:
  - If any req bit is high, pick the winner w = the first set bit searching upward (with wrap) from index ptr.
  - Next edge: state=COUNT, grant=onehot(w), busy=1, q=0, target=len[w] latched, ptr=(w+1) mod N_REQ.
  - If no req bit is high, stay in IDLE with all outputs at 0.
- COUNT:
  - If req[w]=0: abort. Next edge: state=IDLE, grant=0, busy=0, q=0. No done pulse. ptr keeps its advanced value.
  - Else if q==target: next edge state=DONE, done[w]=1, q holds target, grant holds.
  - Else: q<=q+1.
- DONE:
  - Next edge: state=IDLE, grant=0, done=0, busy=0, q=0.
  - Lasts exactly one cycle and cannot be aborted.
- Timing for len=L, with req first sampled high at edge E0:
  - grant rises at E1.
  - done is high from E(L+2) to E(L+3).
  - grant falls at E(L+3).
  - grant is high for exactly L+2 cycles.
- len=0: COUNT lasts one cycle with q=0, then DONE.
- len is sampled only at grant. Changes to len during COUNT are ignored.
- The counter never wraps, because target ≤ 2^WIDTH−1. q saturates at target in DONE.
- Re-arbitration gap: at least one IDLE cycle between consecutive grants.
- A requester holding req high after done:
  - Is re-granted only after every other pending requester, per round-robin order.
  - Is re-granted immediately if it is the only one requesting.
- Simultaneous abort and q==target in the same COUNT cycle: abort wins, no done.
- Reset asserted mid-COUNT or in DONE: all outputs clear at that edge, with no done pulse.
- Invariants: at most one grant bit high; done ⊆ grant; busy == |grant.

Decomposition:
- Package counter_arb_pkg holds:
  - state localparams: IDLE=2'd0, COUNT=2'd1, DONE=2'd2
  - default WIDTH and N_REQ.
- One sub-module: rr_arbiter.
  - Purely combinational: inputs req and ptr; outputs onehot winner and its index.
  - Instantiated once.
- The counter register and FSM stay in counter_interval_arbiter.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles with req=4'b1111. Then: grant=0, done=0, q=0, busy=0. Release reset with req=0: outputs stay 0 for 5 cycles.
- Single interval: req=4'b0010 with len[1]=3 (N_REQ=4, WIDTH=4). Then:
  - grant=4'b0010 for exactly 5 cycles
  - q sequence 0,1,2,3,3
  - done[1] high in cycle 5 only.
- Round-robin fairness: req=4'b1011 held continuously, all len=1. Grant order is 0,1,3,0,1,3, each grant 3 cycles with one idle cycle between.
- Abort: req[2] with len=9. Drop req[2] when q=4. Then: the next edge gives grant=0, q=0, and done never pulses. A subsequent req[0] is granted one cycle later.
- len=0 and len=15:
  - len=0: grant lasts 2 cycles, done at the 2nd.
  - len=15: q reaches 15, no wrap to 0, done at the 17th grant cycle.
- Reset mid-operation: assert reset=0 while q=6 in COUNT. At that edge all outputs clear and ptr=0. With req=4'b1000 afterwards, grant=4'b1000.
